// File: rtl/apb_uart_master_if.sv
// apb_uart_master_if: command/response port plus APB initiator bus of apb_uart_master.
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata - local command handshake
//   rsp_valid/rsp_rdata/rsp_err                     - one-cycle response
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA               - APB request (master drives)
//   PRDATA/PREADY/PSLVERR                           - APB completion (slave drives)
// Modports: master (the APB initiator), slave (command source and APB target side).
interface apb_uart_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  PSELx;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA
   );
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_uart_master.sv
// apb_uart_master: single-outstanding APB initiator turning local commands into SETUP/ACCESS transfers.
// Ports:
//   PCLK   - clock, rising edge
//   PRESET - synchronous active-high reset
//   bus    - apb_uart_master_if.master (command in, response out, APB initiator signals)
// Optional: define APB_UART_MASTER_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles without PREADY (response flagged as error).
module apb_uart_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic               PCLK,
   input logic               PRESET,
   apb_uart_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   typedef struct packed {
      state_t                st;
      logic                  psel;
      logic                  penable;
      logic                  pwrite;
      logic [ADDR_WIDTH-1:0] paddr;
      logic [DATA_WIDTH-1:0] pwdata;
      logic                  rsp_valid;
      logic [DATA_WIDTH-1:0] rsp_rdata;
      logic                  rsp_err;
   } regs_t;
   regs_t r, r_n;
   logic  expire;
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end
`ifdef APB_UART_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt, cnt_n;
   // expire flags the edge on which the TIMEOUT_CYCLES-th stalled ACCESS cycle ends
   assign expire = (cnt == CW'(TIMEOUT_CYCLES - 1));
   always_comb cnt_n = (r.st == SETUP) ? '0 : (r.st == ACCESS && !bus.PREADY) ? cnt + 1'b1 : cnt;
   always_ff @(posedge PCLK) cnt <= PRESET ? '0 : cnt_n;
`else
   assign expire = 1'b0;
`endif
   always_comb begin
      r_n = r;
      r_n.rsp_valid = 1'b0;
      case (r.st)
         IDLE: if (bus.cmd_valid) begin
            r_n.st = SETUP;
            r_n.psel = 1'b1;
            r_n.penable = 1'b0;
            r_n.pwrite = bus.cmd_write;
            r_n.paddr = bus.cmd_addr;
            r_n.pwdata = bus.cmd_wdata;
         end
         SETUP: begin
            r_n.st = ACCESS;
            r_n.penable = 1'b1;
         end
         ACCESS: if (bus.PREADY || expire) begin
            // PREADY wins over a simultaneous timeout
            r_n.st = IDLE;
            r_n.psel = 1'b0;
            r_n.penable = 1'b0;
            r_n.rsp_valid = 1'b1;
            r_n.rsp_err = bus.PREADY ? bus.PSLVERR : 1'b1;
            r_n.rsp_rdata = (bus.PREADY && !r.pwrite) ? bus.PRDATA : '0;
         end
         default: r_n.st = IDLE;
      endcase
   end
   always_ff @(posedge PCLK) r <= PRESET ? '0 : r_n;
   assign bus.cmd_ready = (r.st == IDLE);
   assign bus.PSELx     = r.psel;
   assign bus.PENABLE   = r.penable;
   assign bus.PWRITE    = r.pwrite;
   assign bus.PADDR     = r.paddr;
   assign bus.PWDATA    = r.pwdata;
   assign bus.rsp_valid = r.rsp_valid;
   assign bus.rsp_rdata = r.rsp_rdata;
   assign bus.rsp_err   = r.rsp_err;
endmodule

// File: tb/tb_apb_uart_master.sv
// tb_apb_uart_master: randomized transaction-level check of apb_uart_master acting as APB slave and command source.
// Ports: none (instantiates apb_uart_master_if and apb_uart_master).
// Honors APB_UART_MASTER_TIMEOUT_EN to exercise the timeout abort instead of an unbounded wait.
module tb_apb_uart_master;
   logic PCLK;
   logic PRESET;
   int   n_chk;
   int   n_pass;
   logic [31:0] last_rdata;
   logic        last_err;
   apb_uart_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   apb_uart_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .PCLK(PCLK),
      .PRESET(PRESET),
      .bus(bus.master)
   );
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic step();
      @(posedge PCLK);
      @(negedge PCLK);
   endtask
   // idle cycles: bus quiet, response fields keep their last value
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
         check("idle_psel", 64'(bus.PSELx), 64'(0));
         check("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));
         check("idle_rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(last_rdata));
         check("idle_rsp_err_hold", 64'(bus.rsp_err), 64'(last_err));
      end
   endtask
   // one complete transfer; called at a negedge, returns at the negedge after completion
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                       input logic [31:0] rd, input logic er, input logic hold);
      check("cmd_ready_before", 64'(bus.cmd_ready), 64'(1));
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      bus.PREADY    = 1'b1;
      bus.PSLVERR   = 1'b1;
      bus.PRDATA    = $urandom;
      step();
      if (hold) begin
         bus.cmd_write = 1'($urandom);
         bus.cmd_addr  = $urandom;
         bus.cmd_wdata = $urandom;
      end else bus.cmd_valid = 1'b0;
      check("setup_psel", 64'(bus.PSELx), 64'(1));
      check("setup_penable", 64'(bus.PENABLE), 64'(0));
      check("setup_paddr", 64'(bus.PADDR), 64'(a));
      check("setup_pwrite", 64'(bus.PWRITE), 64'(w));
      check("setup_pwdata", 64'(bus.PWDATA), 64'(d));
      check("setup_cmd_ready", 64'(bus.cmd_ready), 64'(0));
      check("setup_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      step();
      check("access_psel", 64'(bus.PSELx), 64'(1));
      check("access_penable", 64'(bus.PENABLE), 64'(1));
      for (int i = 0; i <= waits; i++) begin
         if (i > 0) begin
            check("wait_psel", 64'(bus.PSELx), 64'(1));
            check("wait_penable", 64'(bus.PENABLE), 64'(1));
            check("wait_paddr", 64'(bus.PADDR), 64'(a));
            check("wait_pwdata", 64'(bus.PWDATA), 64'(d));
            check("wait_rsp_valid", 64'(bus.rsp_valid), 64'(0));
         end
         bus.PREADY  = (i == waits);
         bus.PSLVERR = (i == waits) ? er : 1'b1;
         bus.PRDATA  = (i == waits) ? rd : $urandom;
         step();
      end
      bus.cmd_valid = 1'b0;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
      last_rdata = w ? 32'h0 : rd;
      last_err   = er;
      check("rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("rsp_rdata", 64'(bus.rsp_rdata), 64'(last_rdata));
      check("rsp_err", 64'(bus.rsp_err), 64'(last_err));
      check("done_psel", 64'(bus.PSELx), 64'(0));
      check("done_penable", 64'(bus.PENABLE), 64'(0));
      check("done_paddr_held", 64'(bus.PADDR), 64'(a));
      check("done_pwdata_held", 64'(bus.PWDATA), 64'(d));
      check("done_pwrite_held", 64'(bus.PWRITE), 64'(w));
      check("done_cmd_ready", 64'(bus.cmd_ready), 64'(1));
   endtask
   initial begin
      n_chk = 0;
      n_pass = 0;
      last_rdata = 32'h0;
      last_err = 1'b0;
      PRESET = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h0;
      bus.cmd_wdata = 32'h0;
      bus.PRDATA    = 32'h0;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
      step();
      step();
      PRESET = 1'b0;
      check("rst_psel", 64'(bus.PSELx), 64'(0));
      check("rst_penable", 64'(bus.PENABLE), 64'(0));
      check("rst_pwrite", 64'(bus.PWRITE), 64'(0));
      check("rst_paddr", 64'(bus.PADDR), 64'(0));
      check("rst_pwdata", 64'(bus.PWDATA), 64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
      check("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      idle(1);
      xfer(1'b1, 32'h4, 32'hA5, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      idle(1);
      xfer(1'b0, 32'h8, 32'h1234, 3, 32'h5A, 1'b0, 1'b0);
      idle(2);
      xfer(1'b0, 32'hFF, 32'h0, 0, 32'hC0FF_EE00, 1'b1, 1'b0);
      idle(1);
      // back-to-back with cmd_valid held: handshakes three edges apart
      xfer(1'b1, 32'h10, 32'h11, 0, 32'h0, 1'b0, 1'b1);
      xfer(1'b1, 32'h14, 32'h22, 0, 32'h0, 1'b0, 1'b1);
      xfer(1'b1, 32'h18, 32'h33, 0, 32'h0, 1'b0, 1'b0);
      idle(1);
      // reset while the slave stalls the ACCESS phase
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h20;
      step();
      bus.cmd_valid = 1'b0;
      step();
      bus.PREADY = 1'b0;
      step();
      check("mid_still_access", 64'(bus.PENABLE), 64'(1));
      PRESET = 1'b1;
      step();
      check("midrst_psel", 64'(bus.PSELx), 64'(0));
      check("midrst_penable", 64'(bus.PENABLE), 64'(0));
      check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("midrst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check("midrst_paddr", 64'(bus.PADDR), 64'(0));
      PRESET = 1'b0;
      last_rdata = 32'h0;
      last_err = 1'b0;
      idle(2);
`ifdef APB_UART_MASTER_TIMEOUT_EN
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h30;
      bus.PREADY    = 1'b0;
      step();
      bus.cmd_valid = 1'b0;
      step();
      for (int i = 1; i < 16; i++) begin
         bus.PRDATA = $urandom;
         step();
         check("to_wait_penable", 64'(bus.PENABLE), 64'(1));
         check("to_wait_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      end
      step();
      last_rdata = 32'h0;
      last_err = 1'b1;
      check("to_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("to_rsp_err", 64'(bus.rsp_err), 64'(1));
      check("to_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
      check("to_psel", 64'(bus.PSELx), 64'(0));
      check("to_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      idle(1);
`else
      xfer(1'b0, 32'h30, 32'h0, 20, 32'h7777_1111, 1'b0, 1'b0);
      idle(1);
`endif
      for (int t = 0; t < 40; t++) begin
         xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 4)), $urandom,
              ($urandom_range(0, 3) == 0), 1'($urandom));
         idle(int'($urandom_range(0, 2)));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
